// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op-codes and response-buffer states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; carry_out is meaningful only for add (carry) and sub (borrow).
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] alu_sel,
  output logic [3:0] alu_out,
  output logic       carry_out
);

  logic [4:0] sum5;
  logic [4:0] diff5;

  assign sum5  = {1'b0, a} + {1'b0, b};
  assign diff5 = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_out   = sum5[3:0];
        carry_out = sum5[4];
      end
      OP_SUB: begin
        alu_out   = diff5[3:0];
        carry_out = diff5[4];
      end
      OP_AND: alu_out = a & b;
      OP_OR:  alu_out = a | b;
      OP_XOR: alu_out = a ^ b;
      OP_NOT: alu_out = ~a;
      OP_SHL: alu_out = {a[2:0], 1'b0};
      OP_SHR: alu_out = {1'b0, a[3:1]};
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_4bit between two channels, with a single-entry
// response buffer and saturating per-channel grant counters.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_p1, state_nxt;
  logic             ptr_p1;
  logic             can_accept, gnt_vld, gnt_id;
  logic [2:0]       op_p0;
  logic [3:0]       a_p0, b_p0, alu_res;
  logic             alu_cy, carry_p0;
  logic             id_p1, carry_p1;
  logic [3:0]       result_p1;
  logic [CNT_W-1:0] cnt0_p1, cnt1_p1;

  // Stage p0: arbitration and ALU drive from the granted channel
  always_comb begin
    state_nxt  = state_p1;
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    can_accept = (state_p1 == EMPTY) || rsp_ready;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ptr_p1;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    if (gnt_vld) state_nxt = FULL;
    else if ((state_p1 == FULL) && rsp_ready) state_nxt = EMPTY;
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld && gnt_id;

  always_comb begin
    op_p0 = '0;
    a_p0  = '0;
    b_p0  = '0;
    if (gnt_vld) begin
      op_p0 = gnt_id ? req1_op : req0_op;
      a_p0  = gnt_id ? req1_a  : req0_a;
      b_p0  = gnt_id ? req1_b  : req0_b;
    end
  end

  alu_4bit u_alu (
    .a         (a_p0),
    .b         (b_p0),
    .alu_sel   (op_p0),
    .alu_out   (alu_res),
    .carry_out (alu_cy)
  );

  // Carry only has meaning for add/sub; every other op reports 0.
  assign carry_p0 = ((op_p0 == OP_ADD) || (op_p0 == OP_SUB)) ? alu_cy : 1'b0;

  // Stage p1: response buffer, priority pointer and grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p1 <= EMPTY;
    else     state_p1 <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p1    <= PRIO_INIT;
      id_p1     <= 1'b0;
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      cnt0_p1   <= '0;
      cnt1_p1   <= '0;
    end else if (gnt_vld) begin
      ptr_p1    <= ~gnt_id;
      id_p1     <= gnt_id;
      result_p1 <= alu_res;
      carry_p1  <= carry_p0;
      if (gnt_id) cnt1_p1 <= sat_inc(cnt1_p1);
      else        cnt0_p1 <= sat_inc(cnt0_p1);
    end
  end

  assign rsp_valid  = (state_p1 == FULL);
  assign rsp_id     = id_p1;
  assign rsp_result = result_p1;
  assign rsp_carry  = carry_p1;
  assign grant_cnt0 = cnt0_p1;
  assign grant_cnt1 = cnt1_p1;

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one alu_4bit datapath between two requesters (ch0, ch1) using round-robin arbitration and a valid/ready handshake. Each granted request drives the ALU operands and op-select for one cycle. The block registers the result, carry and originating channel ID in a single-entry response buffer. It also keeps saturating per-channel grant counters for debug and performance readout.

Parameters:
PRIO_INIT, 0, channel that holds priority after reset (0 or 1)
CNT_W, 8, width of each saturating grant counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  ch0 request valid
req0_ready  output  1  ch0 request accepted this cycle
req0_op  input  3  ch0 op-select, same encoding as ALU_Sel
req0_a  input  4  ch0 operand A
req0_b  input  4  ch0 operand B
req1_valid  input  1  ch1 request valid
req1_ready  output  1  ch1 request accepted this cycle
req1_op  input  3  ch1 op-select
req1_a  input  4  ch1 operand A
req1_b  input  4  ch1 operand B
rsp_valid  output  1  response buffer holds a result
rsp_ready  input  1  consumer takes the response
rsp_id  output  1  channel that issued the response
rsp_result  output  4  ALU result
rsp_carry  output  1  carry/borrow flag
grant_cnt0  output  CNT_W  saturating count of ch0 grants
grant_cnt1  output  CNT_W  saturating count of ch1 grants

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high. All state is cleared on assertion of rst, independent of clk.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0
  - grant_cnt0=0, grant_cnt1=0
  - priority pointer = PRIO_INIT
  - FSM in EMPTY
- FSM states:
  - EMPTY: response buffer free.
  - FULL: buffer holds an undelivered response.
- Accept condition: can_accept = (state==EMPTY) or (rsp_valid and rsp_ready). A drain and a refill in the same cycle are allowed, giving 1 result/cycle sustained.
- Grant (combinational, only when can_accept):
  - If only one channel is valid, grant that channel.
  - If both are valid, grant the channel named by the priority pointer.
  - reqN_ready is high only for the granted channel. It is never high when can_accept=0.
- On a grant, at the clock edge:
  - Capture ALU outputs into rsp_result/rsp_carry.
  - Set rsp_id to the granted channel.
  - Go to (or stay in) FULL.
  - Set the priority pointer to the other channel.
- Pointer update rule: the pointer changes only on a grant; idle cycles leave it unchanged.
- Drain without refill (rsp_ready=1, no grant): EMPTY, rsp_valid=0. rsp_result/rsp_id hold their last values.
- Latency: a request accepted at edge k has rsp_valid=1 after edge k, i.e. one cycle.
- FULL with rsp_ready=0: rsp_* outputs are held stable, both readies are 0, and requesters must hold their requests.
- ALU drive: the ALU is fed the granted channel's op/a/b. When there is no grant, it is fed zeros.
- Carry rules, normalised here:
  - op 000 (add): rsp_carry = bit 4 of the 5-bit sum.
  - op 001 (sub): rsp_carry = bit 4 of the 5-bit A-B, i.e. 1 when A<B (borrow).
  - All other ops: rsp_carry = 0. The block forces 0 rather than using the ALU's held carry.
- Grant counters: increment by 1 on each grant to their channel. Saturate at 2^CNT_W-1 with no wrap.
- Reset during FULL: the pending response is discarded, rsp_valid drops asynchronously, and the pointer returns to PRIO_INIT.

Decomposition:
- Shared package alu_pkg:
  - Op-code localparams: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_SHL=110, OP_SHR=111.
  - FSM state encoding: EMPTY=0, FULL=1.
- One sub-module: instantiate the existing alu_4bit as u_alu. The arbiter and response buffer stay in this module.

Test Plan:
- Reset, then ch0 alone issues op=000, a=9, b=8 -> req0_ready=1. Next cycle: rsp_valid=1, rsp_id=0, rsp_result=1, rsp_carry=1, grant_cnt0=1.
- PRIO_INIT=0, both channels valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 with one response per cycle. ch1 op=001, a=3, b=5 gives rsp_result=14 (0xE), rsp_carry=1.
- rsp_ready=0 for 4 cycles while both channels are valid -> after the first grant, readies stay 0 and rsp_* is held. Releasing rsp_ready gives a same-cycle drain and refill with the grant going to the other channel.
- ch1 op=010 (AND) issued right after an add that produced carry=1 -> rsp_carry=0.
- CNT_W=2, ch0 alone for 5 grants -> grant_cnt0 saturates at 3.
- Assert rst mid-cycle while FULL -> rsp_valid=0 immediately, counters=0, and the first post-reset contention is granted to PRIO_INIT.
